// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT stage scheduler: FSM state encoding,
// default geometry of the 4-BFU radix-2 core and derived address-map constants.
package ntt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int N_LOG_DEF    = 8;
    localparam int BFU_LOG_DEF  = 2;
    localparam int PIPE_LAT_DEF = 7;

    // Rows per bank: N coefficients spread over 2*BFU banks.
    localparam int ROWS_DEF     = 1 << (N_LOG_DEF - BFU_LOG_DEF - 1);

    // Inverse twiddles live directly above the forward ones.
    localparam int TW_INV_BASE  = N_LOG_DEF * ROWS_DEF;

    // Twiddle ROM must hold both the forward and the inverse regions.
    localparam int TW_W_DEF     = $clog2(2 * TW_INV_BASE);

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
// Used to align write-back strobes/addresses with the butterfly pipeline.
module ntt_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    // Next contents: new word enters at tap 0, every tap moves one step along.
    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Shift register; clear drops anything in flight so nothing stale emerges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// Stage scheduler for the radix-2, 4-BFU NTT core.
// Walks all N_LOG butterfly stages, issuing bank read rows and twiddle ROM
// words, and replays the read stream PIPE_LAT cycles later as write-backs.
// Each stage is followed by a PIPE_LAT-cycle drain so in-place writes land
// before the next stage reads.
// Optional feature macro: NTT_STAGE_CTRL_INTT_EN adds the `mode` port and
// selects the inverse twiddle region when mode=1.
module ntt_stage_ctrl
    import ntt_pkg::*;
#(
    parameter int N_LOG    = N_LOG_DEF,
    parameter int BFU_LOG  = BFU_LOG_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int ADDR_W   = N_LOG - BFU_LOG - 1,
    parameter int TW_W     = TW_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
`ifdef NTT_STAGE_CTRL_INTT_EN
    input  logic                      mode,
`endif
    output logic                      busy,
    output logic                      done,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    output logic [TW_W-1:0]           tw_addr,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [$clog2(N_LOG)-1:0]  stage
);

    localparam int ROWS    = 1 << ADDR_W;
    localparam int STAGE_W = $clog2(N_LOG);
    localparam int CNT_W   = $clog2(PIPE_LAT + 1);
`ifdef NTT_STAGE_CTRL_INTT_EN
    localparam int TW_INV  = N_LOG * ROWS;
`endif

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    row_q, row_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`ifdef NTT_STAGE_CTRL_INTT_EN
    logic                 mode_q, mode_d;
`endif

    logic                 rd_en_q, rd_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [TW_W-1:0]      tw_addr_q, tw_addr_d;

    logic [ADDR_W:0]      dly_out;

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            stage_q   <= '0;
            cnt_q     <= '0;
`ifdef NTT_STAGE_CTRL_INTT_EN
            mode_q    <= 1'b0;
`endif
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tw_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            stage_q   <= stage_d;
            cnt_q     <= cnt_d;
`ifdef NTT_STAGE_CTRL_INTT_EN
            mode_q    <= mode_d;
`endif
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tw_addr_q <= tw_addr_d;
        end
    end

    // Next state and counter updates; counters stop at their last value, never wrap.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
`ifdef NTT_STAGE_CTRL_INTT_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    row_d   = '0;
                    stage_d = '0;
`ifdef NTT_STAGE_CTRL_INTT_EN
                    mode_d  = mode;
`endif
                end
            end
            READ: begin
                if (row_q == ADDR_W'(ROWS - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(PIPE_LAT - 1)) begin
                    if (stage_q == STAGE_W'(N_LOG - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                        stage_d = stage_q + 1'b1;
                        row_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                row_d   = '0;
                stage_d = '0;
`ifdef NTT_STAGE_CTRL_INTT_EN
                mode_d  = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so they register cleanly.
    always_comb begin
        rd_en_d   = (state_d == READ);
        busy_d    = (state_d == READ) || (state_d == DRAIN);
        done_d    = (state_d == DONE);
        // ROWS is a power of two, so stage*ROWS + row is a plain concatenation.
        tw_addr_d = TW_W'({stage_d, row_d});
`ifdef NTT_STAGE_CTRL_INTT_EN
        if (mode_d) begin
            tw_addr_d = tw_addr_d + TW_W'(TW_INV);
        end
`endif
    end

    ntt_delay_line #(
        .DEPTH (PIPE_LAT),
        .WIDTH (ADDR_W + 1)
    ) u_wr_dly (
        .clk   (clk),
        .rst_n (rst),
        .din   ({rd_en_q, row_q}),
        .dout  (dly_out)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = row_q;
    assign tw_addr = tw_addr_q;
    assign stage   = stage_q;
    assign wr_en   = dly_out[ADDR_W];
    assign wr_addr = dly_out[ADDR_W-1:0];

endmodule
